// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for the 8-bit ExceptioNull datapath.
// Owns pc and ir; drives the register file, ALU, sign-extension unit and memory handshakes.
//
// state     | meaning
// S_FETCH   | imem_req high until imem_ack; latch ir, pc+1
// S_DECODE  | imm_out driven, opcode classified
// S_EXECUTE | ALU controls valid; BEQZ resolves here
// S_MEM     | dmem_req high until dmem_ack
// S_WRITEBACK | one-cycle rf_we strobe
// S_HALT    | absorbing; only reset leaves
module instruction_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic [1:0] imm_out,
  output logic [1:0] rf_raddr_a,
  output logic [1:0] rf_raddr_b,
  input  logic       reg_a_zero,
  output logic       rf_we,
  output logic [1:0] rf_waddr,
  output logic       wb_sel,
  output logic [1:0] alu_op,
  output logic       alu_src_imm,
  output logic [7:0] pc,
  output logic       halted,
  output logic       illegal_op
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_LI   = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQZ = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state, state_nxt;
  logic [7:0] pc_q;
  logic [7:0] ir;
  logic [7:0] sext_q;
  logic       armed;
  logic [3:0] opcode;
  logic       op_defined;
  logic       fetch_done;
  logic       mem_done;

  assign opcode     = ir[7:4];
  assign op_defined = (opcode <= OP_BEQZ) || (opcode == OP_HALT);
  assign fetch_done = imem_req && imem_ack;
  assign mem_done   = dmem_req && dmem_ack;

  // armed holds imem_req low until the first edge after reset is released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // sext_q mirrors the external registered extender so the branch adder sees the same value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= PC_RESET;
      ir     <= 8'h00;
      sext_q <= 8'h00;
    end else begin
      if (state == S_FETCH && fetch_done) begin
        ir   <= imem_rdata;
        pc_q <= pc_q + 8'd1;
      end
      if (state == S_DECODE)
        sext_q <= {{6{ir[1]}}, ir[1:0]};
      if (state == S_EXECUTE && opcode == OP_BEQZ && reg_a_zero)
        pc_q <= pc_q + sext_q;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:
        if (fetch_done) state_nxt = S_DECODE;
      S_DECODE:
        if (opcode == OP_HALT)                     state_nxt = S_HALT;
        else if (opcode == OP_NOP || !op_defined)  state_nxt = S_FETCH;
        else                                       state_nxt = S_EXECUTE;
      S_EXECUTE:
        if (opcode == OP_LW || opcode == OP_SW) state_nxt = S_MEM;
        else if (opcode == OP_BEQZ)             state_nxt = S_FETCH;
        else                                    state_nxt = S_WRITEBACK;
      S_MEM:
        if (mem_done) state_nxt = (opcode == OP_LW) ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK:
        state_nxt = S_FETCH;
      S_HALT:
        state_nxt = S_HALT;
      default:
        state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    imm_out     = 2'b00;
    rf_we       = 1'b0;
    rf_waddr    = 2'b00;
    wb_sel      = 1'b0;
    alu_op      = 2'b00;
    alu_src_imm = 1'b0;
    halted      = 1'b0;
    illegal_op  = 1'b0;
    case (state)
      S_FETCH:
        imem_req = armed;
      S_DECODE: begin
        imm_out    = ir[1:0];
        illegal_op = !op_defined;
      end
      S_EXECUTE:
        case (opcode)
          OP_SUB:  alu_op = 2'b01;
          OP_ADDI: alu_src_imm = 1'b1;
          OP_LI: begin
            alu_op      = 2'b10;
            alu_src_imm = 1'b1;
          end
          default: alu_op = 2'b00;
        endcase
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_SW);
      end
      S_WRITEBACK: begin
        rf_we    = 1'b1;
        rf_waddr = ir[3:2];
        wb_sel   = (opcode == OP_LW);
      end
      S_HALT:
        halted = 1'b1;
      default: ;
    endcase
  end

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign rf_raddr_a = ir[3:2];
  assign rf_raddr_b = ir[1:0];

endmodule
